// File: rtl/uart_buffered_if_pkg.sv
// Shared definitions for the buffered UART front end: register addresses,
// STATUS bit positions and the TX hand-off state encoding.
package uart_buffered_if_pkg;

    // Register map addresses
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_STAT = 2'd1;
    localparam logic [1:0] ADDR_IER  = 2'd2;
    localparam logic [1:0] ADDR_CNT  = 2'd3;

    // STATUS register bit positions
    localparam int ST_RXRDY   = 0;
    localparam int ST_TXRDY   = 1;
    localparam int ST_PERR    = 2;
    localparam int ST_FERR    = 3;
    localparam int ST_OVF     = 4;
    localparam int ST_TXOVF   = 5;
    localparam int ST_THR     = 6;
    localparam int ST_TXEMPTY = 7;

    // TX engine hand-off states
    typedef enum logic [1:0] {
        T_IDLE   = 2'd0,
        T_ACCEPT = 2'd1,
        T_SEND   = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_buffered_if_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Pushes while full and pops while empty are ignored here; callers decide
// how to flag them.
module uart_buffered_if_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign dout      = mem_q[rd_ptr_q];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Next pointer and occupancy values; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_buffered_if.sv
// Buffered UART host interface: register map, TX/RX FIFOs, sticky error
// flags, RX threshold and maskable interrupt in front of the serial engines.
module uart_buffered_if
    import uart_buffered_if_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int TX_DEPTH  = 16,
    parameter int RX_DEPTH  = 16,
    parameter int RX_THRESH = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [1:0]        ADDR,
    input  logic              RD,
    input  logic              WR,
    input  logic [7:0]        OUT_PORT,
    output logic [7:0]        IN_PORT,
    output logic              INT,
    output logic [DATA_W-1:0] TX_DATA,
    output logic              TX_LOAD,
    input  logic              TX_RDY,
    input  logic [DATA_W-1:0] RX_DATA,
    input  logic              RX_VALID,
    input  logic              RX_PERR,
    input  logic              RX_FERR
);

    localparam int RXW   = DATA_W + 2;
    localparam int TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;
    localparam logic [RX_CW-1:0] THR_LVL = RX_CW'(RX_THRESH);

    // Bus decode; a read always takes priority over a simultaneous write
    logic rd_s, wr_s;
    logic data_rd_s, stat_rd_s, data_wr_s, ier_wr_s;

    assign rd_s      = RD;
    assign wr_s      = WR & ~RD;
    assign data_rd_s = rd_s & (ADDR == ADDR_DATA);
    assign stat_rd_s = rd_s & (ADDR == ADDR_STAT);
    assign data_wr_s = wr_s & (ADDR == ADDR_DATA);
    assign ier_wr_s  = wr_s & (ADDR == ADDR_IER);

    // RX FIFO: entries carry {ferr, perr, data}
    logic [RXW-1:0]   rx_din_s, rx_dout_s;
    logic             rx_full_s, rx_empty_s, rx_push_s, rx_pop_s;
    logic [RX_CW-1:0] rx_count_s;

    assign rx_din_s  = {RX_FERR, RX_PERR, RX_DATA};
    assign rx_push_s = RX_VALID & ~rx_full_s;
    assign rx_pop_s  = data_rd_s & ~rx_empty_s;

    uart_buffered_if_sync_fifo #(.WIDTH(RXW), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (CLK),
        .rst_n (RESET),
        .push  (rx_push_s),
        .pop   (rx_pop_s),
        .din   (rx_din_s),
        .dout  (rx_dout_s),
        .full  (rx_full_s),
        .empty (rx_empty_s),
        .count (rx_count_s)
    );

    // TX FIFO
    logic [DATA_W-1:0] tx_dout_s;
    logic              tx_full_s, tx_empty_s, tx_push_s, tx_pop_s;
    logic [TX_CW-1:0]  tx_count_s;

    assign tx_push_s = data_wr_s & ~tx_full_s;

    uart_buffered_if_sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (CLK),
        .rst_n (RESET),
        .push  (tx_push_s),
        .pop   (tx_pop_s),
        .din   (OUT_PORT[DATA_W-1:0]),
        .dout  (tx_dout_s),
        .full  (tx_full_s),
        .empty (tx_empty_s),
        .count (tx_count_s)
    );

    // Registered state
    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_load_q, tx_load_d;
    logic [7:0]        in_port_q, in_port_d;
    logic [7:0]        ier_q, ier_d;
    logic              int_q, int_d;
    logic              perr_q, perr_d, ferr_q, ferr_d;
    logic              ovf_q, ovf_d, txovf_q, txovf_d;

    // Error event sources; flags are raised when the offending entry is read
    logic perr_set_s, ferr_set_s, ovf_set_s, txovf_set_s;

    assign perr_set_s  = rx_pop_s & rx_dout_s[DATA_W];
    assign ferr_set_s  = rx_pop_s & rx_dout_s[DATA_W+1];
    assign ovf_set_s   = RX_VALID & rx_full_s;
    assign txovf_set_s = data_wr_s & tx_full_s;

    // TX hand-off FSM: load one character, wait for engine busy, then idle
    always_comb begin
        state_d  = state_q;
        tx_pop_s = 1'b0;
        case (state_q)
            T_IDLE: begin
                if (!tx_empty_s && TX_RDY) begin
                    tx_pop_s = 1'b1;
                    state_d  = T_ACCEPT;
                end else begin
                    state_d  = T_IDLE;
                end
            end
            T_ACCEPT: begin
                if (!TX_RDY) begin
                    state_d = T_SEND;
                end else begin
                    state_d = T_ACCEPT;
                end
            end
            T_SEND: begin
                if (TX_RDY) begin
                    state_d = T_IDLE;
                end else begin
                    state_d = T_SEND;
                end
            end
            default: state_d = T_IDLE;
        endcase
    end

    // STATUS assembly from live FIFO state and sticky flags
    logic [7:0] status_s;
    always_comb begin
        status_s             = 8'h00;
        status_s[ST_RXRDY]   = ~rx_empty_s;
        status_s[ST_TXRDY]   = ~tx_full_s;
        status_s[ST_PERR]    = perr_q;
        status_s[ST_FERR]    = ferr_q;
        status_s[ST_OVF]     = ovf_q;
        status_s[ST_TXOVF]   = txovf_q;
        status_s[ST_THR]     = (rx_count_s >= THR_LVL);
        status_s[ST_TXEMPTY] = (tx_count_s == '0) && (state_q == T_IDLE);
    end

    // Read data mux, register writes, sticky flags and interrupt next-state
    logic [7:0] rx_data_ext_s;
    always_comb begin
        rx_data_ext_s                = 8'h00;
        rx_data_ext_s[DATA_W-1:0]    = rx_dout_s[DATA_W-1:0];
        in_port_d = in_port_q;
        if (rd_s) begin
            case (ADDR)
                ADDR_DATA: in_port_d = rx_empty_s ? 8'h00 : rx_data_ext_s;
                ADDR_STAT: in_port_d = status_s;
                ADDR_IER:  in_port_d = ier_q;
                ADDR_CNT:  in_port_d = 8'(rx_count_s);
                default:   in_port_d = in_port_q;
            endcase
        end else begin
            in_port_d = in_port_q;
        end
        if (ier_wr_s) begin
            ier_d = OUT_PORT;
        end else begin
            ier_d = ier_q;
        end
        // Clear-on-status-read, with a same-cycle set taking precedence
        perr_d    = (perr_q  & ~stat_rd_s) | perr_set_s;
        ferr_d    = (ferr_q  & ~stat_rd_s) | ferr_set_s;
        ovf_d     = (ovf_q   & ~stat_rd_s) | ovf_set_s;
        txovf_d   = (txovf_q & ~stat_rd_s) | txovf_set_s;
        int_d     = |(status_s & ier_q);
        tx_load_d = tx_pop_s;
        if (tx_pop_s) begin
            tx_data_d = tx_dout_s;
        end else begin
            tx_data_d = tx_data_q;
        end
    end

    // All block state with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q   <= T_IDLE;
            tx_data_q <= '0;
            tx_load_q <= 1'b0;
            in_port_q <= 8'h00;
            ier_q     <= 8'h00;
            int_q     <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
            txovf_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            tx_load_q <= tx_load_d;
            in_port_q <= in_port_d;
            ier_q     <= ier_d;
            int_q     <= int_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
            txovf_q   <= txovf_d;
        end
    end

    assign IN_PORT = in_port_q;
    assign INT     = int_q;
    assign TX_DATA = tx_data_q;
    assign TX_LOAD = tx_load_q;

endmodule

// File: tb/tb_uart_buffered_if.sv
// Directed bench for uart_buffered_if with a simple TX engine model.
module tb_uart_buffered_if;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [1:0] ADDR = 2'd0;
    logic       RD = 1'b0;
    logic       WR = 1'b0;
    logic [7:0] OUT_PORT = 8'h00;
    logic [7:0] IN_PORT;
    logic       INT;
    logic [7:0] TX_DATA;
    logic       TX_LOAD;
    logic       TX_RDY = 1'b1;
    logic [7:0] RX_DATA = 8'h00;
    logic       RX_VALID = 1'b0;
    logic       RX_PERR = 1'b0;
    logic       RX_FERR = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    uart_buffered_if #(.DATA_W(8), .TX_DEPTH(16), .RX_DEPTH(16), .RX_THRESH(8)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .ADDR     (ADDR),
        .RD       (RD),
        .WR       (WR),
        .OUT_PORT (OUT_PORT),
        .IN_PORT  (IN_PORT),
        .INT      (INT),
        .TX_DATA  (TX_DATA),
        .TX_LOAD  (TX_LOAD),
        .TX_RDY   (TX_RDY),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .RX_PERR  (RX_PERR),
        .RX_FERR  (RX_FERR)
    );

    always #5 CLK = ~CLK;

    // TX engine model: log each load, drop TX_RDY 2 cycles later, raise it 3 after that
    logic [7:0] tx_log [$];
    int         eng_cnt = 0;
    logic       eng_busy = 1'b0;
    logic       eng_stall = 1'b0;
    always @(negedge CLK) begin
        if (TX_LOAD === 1'b1) begin
            tx_log.push_back(TX_DATA);
            eng_busy = 1'b1;
            eng_cnt  = 0;
        end else if (eng_busy && !eng_stall) begin
            eng_cnt++;
            if (eng_cnt == 2) TX_RDY = 1'b0;
            if (eng_cnt == 5) begin
                TX_RDY   = 1'b1;
                eng_busy = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge CLK);
        ADDR = a; OUT_PORT = d; WR = 1'b1;
        @(negedge CLK);
        WR = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge CLK);
        ADDR = a; RD = 1'b1;
        @(negedge CLK);
        RD = 1'b0;
        d = IN_PORT;
    endtask

    task automatic rx_push(input logic [7:0] d, input logic pe, input logic fe);
        @(negedge CLK);
        RX_DATA = d; RX_PERR = pe; RX_FERR = fe; RX_VALID = 1'b1;
        @(negedge CLK);
        RX_VALID = 1'b0; RX_PERR = 1'b0; RX_FERR = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        int         nlog;

        // Reset state
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        chk("rst_in_port", IN_PORT, 8'h00);
        chk("rst_int", INT, 1'b0);
        chk("rst_tx_load", TX_LOAD, 1'b0);
        chk("rst_tx_data", TX_DATA, 8'h00);
        reg_read(2'd1, rd);
        chk("rst_status", rd, 8'h82);
        chk("rst_int2", INT, 1'b0);

        // RD and WR together: read wins, IER untouched
        @(negedge CLK);
        ADDR = 2'd2; OUT_PORT = 8'hFF; RD = 1'b1; WR = 1'b1;
        @(negedge CLK);
        RD = 1'b0; WR = 1'b0;
        chk("rdwr_in_port", IN_PORT, 8'h00);
        reg_read(2'd2, rd);
        chk("rdwr_ier", rd, 8'h00);

        // TX: two characters through the engine handshake
        reg_write(2'd0, 8'h41);
        reg_write(2'd0, 8'h42);
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (tx_log.size() == 2 && !eng_busy) break;
        end
        chk("tx_loads", tx_log.size(), 2);
        if (tx_log.size() >= 2) begin
            chk("tx_char0", tx_log[0], 8'h41);
            chk("tx_char1", tx_log[1], 8'h42);
        end
        @(negedge CLK);
        reg_read(2'd1, rd);
        chk("tx_done_status", rd, 8'h82);
        chk("tx_no_extra_load", tx_log.size(), 2);

        // RX: 17 characters into a 16-deep FIFO
        for (int i = 0; i < 17; i++) rx_push(8'(i), 1'b0, 1'b0);
        reg_read(2'd3, rd);
        chk("rx_count16", rd, 8'd16);
        reg_read(2'd1, rd);
        chk("rx_full_status", rd, 8'hD3);
        for (int i = 0; i < 16; i++) begin
            reg_read(2'd0, rd);
            chk($sformatf("rx_pop%0d", i), rd, 32'(i));
        end
        reg_read(2'd0, rd);
        chk("rx_underflow", rd, 8'h00);
        reg_read(2'd1, rd);
        chk("rx_empty_status", rd, 8'h82);

        // Parity error reported with the data read, then cleared by status read
        reg_write(2'd2, 8'h04);
        rx_push(8'h55, 1'b1, 1'b0);
        repeat (2) @(negedge CLK);
        chk("perr_int_before_pop", INT, 1'b0);
        reg_read(2'd0, rd);
        chk("perr_data", rd, 8'h55);
        chk("perr_int_same", INT, 1'b0);
        @(negedge CLK);
        chk("perr_int_rise", INT, 1'b1);
        reg_read(2'd1, rd);
        chk("perr_status", rd, 8'h86);
        chk("perr_int_hold", INT, 1'b1);
        @(negedge CLK);
        chk("perr_int_fall", INT, 1'b0);
        reg_read(2'd1, rd);
        chk("perr_cleared", rd, 8'h82);

        // RX threshold interrupt
        reg_write(2'd2, 8'h40);
        for (int i = 0; i < 7; i++) rx_push(8'hA0 + 8'(i), 1'b0, 1'b0);
        @(negedge CLK);
        chk("thr_int_7", INT, 1'b0);
        rx_push(8'hA7, 1'b0, 1'b0);
        chk("thr_int_8_same", INT, 1'b0);
        @(negedge CLK);
        chk("thr_int_8", INT, 1'b1);
        reg_read(2'd0, rd);
        chk("thr_pop_data", rd, 8'hA0);
        @(negedge CLK);
        chk("thr_int_after_pop", INT, 1'b0);

        // Reset while the FSM waits in T_ACCEPT with 3 characters queued
        reg_write(2'd2, 8'hFF);
        eng_stall = 1'b1;
        nlog = tx_log.size();
        @(negedge CLK);
        ADDR = 2'd0; WR = 1'b1;
        for (int i = 0; i < 4; i++) begin
            OUT_PORT = 8'hC0 + 8'(i);
            @(negedge CLK);
        end
        WR = 1'b0;
        @(negedge CLK);
        chk("mid_load_count", tx_log.size(), nlog + 1);
        chk("mid_int", INT, 1'b1);
        pulse_reset();
        chk("mid_rst_tx_load", TX_LOAD, 1'b0);
        chk("mid_rst_int", INT, 1'b0);
        chk("mid_rst_in_port", IN_PORT, 8'h00);
        chk("mid_rst_tx_data", TX_DATA, 8'h00);
        eng_stall = 1'b0;
        repeat (10) @(negedge CLK);
        chk("mid_rst_no_load", tx_log.size(), nlog + 1);
        reg_read(2'd1, rd);
        chk("mid_rst_status", rd, 8'h82);
        reg_read(2'd3, rd);
        chk("mid_rst_rxcount", rd, 8'h00);

        // TX overflow with the engine stalled
        eng_stall = 1'b1;
        for (int i = 0; i < 18; i++) reg_write(2'd0, 8'h10 + 8'(i));
        reg_read(2'd1, rd);
        chk("txovf_status", rd, 8'h20);
        reg_read(2'd1, rd);
        chk("txovf_cleared", rd, 8'h00);
        pulse_reset();
        eng_stall = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_buffered_if.md
Name: uart_buffered_if

Overview:
- Parametrised host-side UART front end: TX and RX FIFOs between the port-mapped processor bus and the existing TX/RX serial engines.
- Adds a four-address register map, per-entry error tracking, sticky error flags with clear-on-read, a programmable RX threshold and a maskable interrupt.
- Sits between the processor I/O port decode and the TX/RX engines.

Parameters:
- DATA_W, 8, character width carried by FIFOs and engines (legal range 5..8).
- TX_DEPTH, 16, TX FIFO entries (power of two, at least 2).
- RX_DEPTH, 16, RX FIFO entries (power of two, at least 2).
- RX_THRESH, 8, RX occupancy at or above which the THR status bit sets (1..RX_DEPTH).

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-low reset
- ADDR  in  2  register select
- RD  in  1  one-cycle read strobe
- WR  in  1  one-cycle write strobe
- OUT_PORT  in  8  write data from processor
- IN_PORT  out  8  registered read data
- INT  out  1  registered interrupt request
- TX_DATA  out  DATA_W  character to TX engine
- TX_LOAD  out  1  one-cycle load pulse to TX engine
- TX_RDY  in  1  TX engine idle
- RX_DATA  in  DATA_W  received character
- RX_VALID  in  1  one-cycle strobe: RX_DATA, RX_PERR and RX_FERR valid
- RX_PERR  in  1  parity error for this character
- RX_FERR  in  1  framing error for this character

Behaviour:
- Clock and reset: one clock (CLK). RESET is synchronous and active-low: when RESET==0 at a CLK edge, all state clears.
- Reset values: IN_PORT=0, INT=0, TX_LOAD=0, TX_DATA=0, both FIFOs empty, IER=0, all sticky flags 0, TX FSM in T_IDLE.
- RD and WR asserted together: WR is ignored and only the read is performed.
- Register map, write (WR):
  - ADDR0: push OUT_PORT[DATA_W-1:0] into the TX FIFO.
  - ADDR2: IER<=OUT_PORT.
  - ADDR1 and ADDR3: ignored.
- Register map, read (RD); IN_PORT is updated on the edge after RD and holds until the next read:
  - ADDR0: pop the RX FIFO head; IN_PORT={zero-extend data}.
  - ADDR1: IN_PORT=STATUS.
  - ADDR2: IN_PORT=IER.
  - ADDR3: IN_PORT=RX occupancy count, zero-extended.
- STATUS bits:
  - [0] RXRDY: RX FIFO not empty.
  - [1] TXRDY: TX FIFO not full.
  - [2] PERR: sticky.
  - [3] FERR: sticky.
  - [4] OVF: RX overflow, sticky.
  - [5] TXOVF: TX overflow, sticky.
  - [6] THR: RX count >= RX_THRESH.
  - [7] TXEMPTY: TX FIFO empty and FSM in T_IDLE.
- RX path:
  - Each RX FIFO entry is {ferr, perr, data}.
  - On RX_VALID with the FIFO not full: push the entry.
  - On RX_VALID with the FIFO full: drop the character and set OVF. This holds even if a pop happens in the same cycle; full is evaluated before the pop.
- PERR/FERR: set when a character carrying that error bit is popped by an ADDR0 read, so the error is reported alongside the data read.
- Sticky clear: PERR, FERR, OVF and TXOVF clear on an ADDR1 read, after IN_PORT has captured their old values. If a set event occurs in the same cycle, set wins.
- RX underflow: ADDR0 read with the RX FIFO empty returns IN_PORT=0, no pop, no flag.
- TX path: write with the TX FIFO full drops the data and sets TXOVF. A write that coincides with an FSM pop when full is still dropped.
- Occupancy: simultaneous push and pop keeps the count unchanged. Pointers wrap modulo depth. Count width is clog2(depth)+1.
- TX FSM:
  - T_IDLE: if the TX FIFO is non-empty and TX_RDY==1, drive TX_DATA=head, pulse TX_LOAD for 1 cycle, pop, go to T_ACCEPT.
  - T_ACCEPT: wait for TX_RDY==0, then go to T_SEND.
  - T_SEND: wait for TX_RDY==1, then go to T_IDLE.
  - TX_DATA holds its value until the next load.
- TX throughput: at most one character in flight; back-to-back characters are separated by at least 1 idle cycle in T_IDLE.
- INT: registered OR of (STATUS & IER), one-cycle latency after the STATUS change.
- Reset mid-operation: the FIFOs flush and the FSM returns to T_IDLE regardless of TX_RDY. A character already loaded into the engine is not tracked.

Decomposition:
- Shared package holds:
  - register address constants ADDR_DATA=0, ADDR_STAT=1, ADDR_IER=2, ADDR_CNT=3;
  - STATUS bit index constants;
  - TX FSM state encoding.
- Sub-module sync_fifo: parameters WIDTH and DEPTH; ports push, pop, din, dout (first-word-fall-through), full, empty, count. It is instantiated twice: TX with WIDTH=DATA_W, RX with WIDTH=DATA_W+2.

Test Plan:
- Reset then read ADDR1 -> IN_PORT=8'h82 (TXRDY=1, TXEMPTY=1), INT=0.
- Write 8'h41, 8'h42 to ADDR0 with TX_RDY held 1 and dropped 2 cycles after each TX_LOAD -> exactly two TX_LOAD pulses with TX_DATA=8'h41 then 8'h42; STATUS[7]=1 after the second TX_RDY rise.
- Push 17 RX_VALID characters (0x00..0x10) into RX_DEPTH=16 -> ADDR3 reads 16, STATUS[4]=1; 16 ADDR0 reads return 0x00..0x0F; a 17th read returns 0 with no pop.
- RX_VALID with data 8'h55 and RX_PERR=1, IER=8'h04 -> PERR and INT stay 0 until the ADDR0 read returns 8'h55; INT rises the cycle after PERR sets; an ADDR1 read returns bit2=1 and clears PERR, with INT falling one cycle later.
- RX_THRESH=8, IER=8'h40: push 7 characters -> INT=0; 8th character -> INT=1 one cycle later; one pop -> INT=0.
- Assert RESET=0 while in T_ACCEPT with 3 characters queued -> next cycle TX FIFO empty, FSM in T_IDLE, TX_LOAD=0, all flags 0.
